enemy_spawn_ctrl: RTL and testbench

//  Schedules enemy tank (re)spawns for a round. It owns a pool of NUM_SLOTS tank_bot instances,

---
 rtl/tank_pkg.sv | 26 ++
 rtl/rr_free_slot_arb.sv | 33 +++
 rtl/enemy_spawn_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_enemy_spawn_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tank_pkg.sv
// ============================================================================
// Module   : tank_pkg
// Brief    : Shared types and spawn-point table for the enemy spawn scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package tank_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT   = 3'd1,
        SELECT = 3'd2,
        CHECK  = 3'd3,
        SPAWN  = 3'd4,
        DONE   = 3'd5
    } spawn_state_t;

    localparam int ENEMY_CNT_W = 6;

    localparam logic [9:0] SPAWN_X [3] = '{10'd32, 10'd224, 10'd416};
    localparam logic [9:0] SPAWN_Y [3] = '{10'd32, 10'd32,  10'd32};

endpackage

`default_nettype wire

// File: rtl/rr_free_slot_arb.sv
// ============================================================================
// Module   : rr_free_slot_arb
// Brief    : Combinational search for the first free slot at or after the
//            round-robin pointer, wrapping around the pool.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_free_slot_arb #(
    parameter int NUM_SLOTS = 2,
    parameter int SLOT_W    = 1
) (
    input  logic [NUM_SLOTS-1:0] i_alive_mask,
    input  logic [SLOT_W-1:0]    i_rr_ptr,
    output logic [NUM_SLOTS-1:0] o_grant,
    output logic                 o_valid
);

    logic [NUM_SLOTS-1:0] w_rot;
    logic [NUM_SLOTS-1:0] w_first;

    // Rotate the free mask so the pointer sits at bit 0, isolate the lowest
    // set bit, then rotate the one-hot back into slot order.
    always_comb begin
        w_rot   = NUM_SLOTS'({~i_alive_mask, ~i_alive_mask} >> i_rr_ptr);
        w_first = w_rot & (~w_rot + NUM_SLOTS'(1));
        o_grant = NUM_SLOTS'(({w_first, w_first} << i_rr_ptr) >> NUM_SLOTS);
        o_valid = |w_rot;
    end

endmodule

`default_nettype wire

// File: rtl/enemy_spawn_ctrl.sv
// ============================================================================
// Module   : enemy_spawn_ctrl
// Brief    : Schedules enemy tank (re)spawns over a slot pool and rotating
//            spawn points. Optional macro SPAWN_FREEZE_EN adds freeze_i.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module enemy_spawn_ctrl
    import tank_pkg::*;
#(
    parameter int NUM_SLOTS       = 2,
    parameter int TOTAL_ENEMIES   = 20,
    parameter int SPAWN_DELAY_SEC = 3,
    parameter int NUM_SPAWN_PTS   = 3
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic                 start_i,
    input  logic                 tick_1s_i,
`ifdef SPAWN_FREEZE_EN
    input  logic                 freeze_i,
`endif
    input  logic [NUM_SLOTS-1:0] slot_die_i,
    input  logic                 spawn_blocked_i,
    output logic [NUM_SLOTS-1:0] slot_revive_o,
    output logic [9:0]           spawn_x_o,
    output logic [9:0]           spawn_y_o,
    output logic [NUM_SLOTS-1:0] alive_mask_o,
    output logic [5:0]           enemy_left_o,
    output logic                 all_cleared_o
);

    localparam int         c_slot_w = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [1:0] c_pts_m1 = 2'(NUM_SPAWN_PTS - 1);
    localparam logic [3:0] c_delay  = 4'(SPAWN_DELAY_SEC);

    spawn_state_t               r_state;
    spawn_state_t               w_state_nxt;
    logic [ENEMY_CNT_W-1:0]     r_pending;
    logic [ENEMY_CNT_W-1:0]     w_pending_nxt;
    logic [ENEMY_CNT_W-1:0]     r_enemy_left;
    logic [ENEMY_CNT_W-1:0]     w_left_nxt;
    logic [NUM_SLOTS-1:0]       r_alive;
    logic [NUM_SLOTS-1:0]       w_alive_nxt;
    logic [NUM_SLOTS-1:0]       r_sel_oh;
    logic [NUM_SLOTS-1:0]       w_grant;
    logic                       w_grant_valid;
    logic [c_slot_w-1:0]        r_rr;
    logic [c_slot_w-1:0]        w_rr_nxt;
    logic [3:0]                 r_delay;
    logic [1:0]                 r_pt_idx;
    logic [1:0]                 w_pt_inc;
    logic [1:0]                 r_block_cnt;
    logic                       w_block_last;
    logic                       w_freeze;

`ifdef SPAWN_FREEZE_EN
    assign w_freeze = freeze_i;
`else
    assign w_freeze = 1'b0;
`endif

    rr_free_slot_arb #(
        .NUM_SLOTS (NUM_SLOTS),
        .SLOT_W    (c_slot_w)
    ) u_arb (
        .i_alive_mask (r_alive),
        .i_rr_ptr     (r_rr),
        .o_grant      (w_grant),
        .o_valid      (w_grant_valid)
    );

    assign w_pt_inc     = (r_pt_idx == c_pts_m1) ? 2'd0 : r_pt_idx + 2'd1;
    assign w_block_last = (r_block_cnt == c_pts_m1);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (start_i) begin
            w_state_nxt = WAIT;
        end else begin
            case (r_state)
                IDLE: w_state_nxt = IDLE;
                WAIT: begin
                    if (!w_freeze) begin
                        if (r_delay == 4'd0 && r_pending != '0 && w_grant_valid) begin
                            w_state_nxt = SELECT;
                        end else if (r_pending == '0 && r_alive == '0) begin
                            w_state_nxt = DONE;
                        end
                    end
                end
                SELECT: w_state_nxt = w_grant_valid ? CHECK : WAIT;
                CHECK: begin
                    if (!spawn_blocked_i) begin
                        w_state_nxt = SPAWN;
                    end else if (w_block_last) begin
                        w_state_nxt = WAIT;
                    end
                end
                SPAWN:   w_state_nxt = WAIT;
                DONE:    w_state_nxt = DONE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        w_rr_nxt = '0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (r_sel_oh[s]) begin
                w_rr_nxt = c_slot_w'((s + 1) % NUM_SLOTS);
            end
        end
    end

    // Die and spawn in one cycle both land; the selected slot is never alive.
    always_comb begin
        if (start_i) begin
            w_alive_nxt   = '0;
            w_pending_nxt = ENEMY_CNT_W'(TOTAL_ENEMIES);
        end else begin
            w_alive_nxt   = r_alive;
            w_pending_nxt = r_pending;
            if (r_state != IDLE) begin
                w_alive_nxt = r_alive & ~slot_die_i;
            end
            if (r_state == SPAWN) begin
                w_alive_nxt = w_alive_nxt | r_sel_oh;
                if (r_pending != '0) begin
                    w_pending_nxt = r_pending - ENEMY_CNT_W'(1);
                end
            end
        end
        w_left_nxt = w_pending_nxt;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (w_alive_nxt[s]) begin
                w_left_nxt = w_left_nxt + ENEMY_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_alive      <= '0;
            r_pending    <= '0;
            r_enemy_left <= '0;
            r_delay      <= 4'd0;
            r_rr         <= '0;
            r_pt_idx     <= 2'd0;
            r_block_cnt  <= 2'd0;
            r_sel_oh     <= '0;
        end else begin
            r_alive      <= w_alive_nxt;
            r_pending    <= w_pending_nxt;
            r_enemy_left <= w_left_nxt;
            if (start_i) begin
                r_delay     <= 4'd0;
                r_block_cnt <= 2'd0;
            end else begin
                case (r_state)
                    WAIT: begin
                        if (tick_1s_i && !w_freeze && r_delay != 4'd0) begin
                            r_delay <= r_delay - 4'd1;
                        end
                    end
                    SELECT: begin
                        r_sel_oh    <= w_grant;
                        r_block_cnt <= 2'd0;
                    end
                    CHECK: begin
                        if (spawn_blocked_i) begin
                            r_pt_idx    <= w_pt_inc;
                            r_block_cnt <= r_block_cnt + 2'd1;
                            // Every point tried: back off one second before retrying.
                            if (w_block_last) begin
                                r_delay <= 4'd1;
                            end
                        end
                    end
                    SPAWN: begin
                        r_rr     <= w_rr_nxt;
                        r_pt_idx <= w_pt_inc;
                        r_delay  <= c_delay;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        slot_revive_o = (r_state == SPAWN) ? r_sel_oh : '0;
        all_cleared_o = (r_state == DONE);
    end

    assign spawn_x_o    = SPAWN_X[r_pt_idx];
    assign spawn_y_o    = SPAWN_Y[r_pt_idx];
    assign alive_mask_o = r_alive;
    assign enemy_left_o = r_enemy_left;

endmodule

`default_nettype wire

// File: tb/tb_enemy_spawn_ctrl.sv
// ============================================================================
// Module   : tb_enemy_spawn_ctrl
// Brief    : Directed self-checking bench for enemy_spawn_ctrl (default and
//            SPAWN_FREEZE_EN builds).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_enemy_spawn_ctrl;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_ni;
    logic       start_i, tick_1s_i, spawn_blocked_i, freeze_i;
    logic [1:0] slot_die_i, slot_revive_o, alive_mask_o;
    logic [9:0] spawn_x_o, spawn_y_o;
    logic [5:0] enemy_left_o;
    logic       all_cleared_o;

    logic       start3, tick3, blocked3, freeze3;
    logic [1:0] die3, rev3, alive3;
    logic [9:0] x3, y3;
    logic [5:0] left3;
    logic       cleared3;

    logic [2:0] block_mask;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         rev_cnt  = 0;
    int         base;
    logic [1:0] got;

    always_comb begin
        spawn_blocked_i = (spawn_x_o == 10'd32  && block_mask[0]) ||
                          (spawn_x_o == 10'd224 && block_mask[1]) ||
                          (spawn_x_o == 10'd416 && block_mask[2]);
    end

    enemy_spawn_ctrl #(
        .NUM_SLOTS(2), .TOTAL_ENEMIES(20), .SPAWN_DELAY_SEC(3), .NUM_SPAWN_PTS(3)
    ) u_dut (
        .clk_i           (clk),
        .reset_ni        (reset_ni),
        .start_i         (start_i),
        .tick_1s_i       (tick_1s_i),
`ifdef SPAWN_FREEZE_EN
        .freeze_i        (freeze_i),
`endif
        .slot_die_i      (slot_die_i),
        .spawn_blocked_i (spawn_blocked_i),
        .slot_revive_o   (slot_revive_o),
        .spawn_x_o       (spawn_x_o),
        .spawn_y_o       (spawn_y_o),
        .alive_mask_o    (alive_mask_o),
        .enemy_left_o    (enemy_left_o),
        .all_cleared_o   (all_cleared_o)
    );

    enemy_spawn_ctrl #(
        .NUM_SLOTS(2), .TOTAL_ENEMIES(3), .SPAWN_DELAY_SEC(3), .NUM_SPAWN_PTS(3)
    ) u_dut3 (
        .clk_i           (clk),
        .reset_ni        (reset_ni),
        .start_i         (start3),
        .tick_1s_i       (tick3),
`ifdef SPAWN_FREEZE_EN
        .freeze_i        (freeze3),
`endif
        .slot_die_i      (die3),
        .spawn_blocked_i (blocked3),
        .slot_revive_o   (rev3),
        .spawn_x_o       (x3),
        .spawn_y_o       (y3),
        .alive_mask_o    (alive3),
        .enemy_left_o    (left3),
        .all_cleared_o   (cleared3)
    );

    always @(negedge clk) begin
        if (slot_revive_o != 2'b00) rev_cnt = rev_cnt + 1;
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start_i = 1'b1; cycles(1); start_i = 1'b0;
    endtask

    task automatic pulse_tick();
        tick_1s_i = 1'b1; cycles(1); tick_1s_i = 1'b0;
    endtask

    task automatic pulse_die(input logic [1:0] m);
        slot_die_i = m; cycles(1); slot_die_i = 2'b00;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_ni = 1'b0; start_i = 1'b0; tick_1s_i = 1'b0; slot_die_i = 2'b00;
        freeze_i = 1'b0; block_mask = 3'b000;
        start3 = 1'b0; tick3 = 1'b0; die3 = 2'b00; blocked3 = 1'b0; freeze3 = 1'b0;
        cycles(3);
        check_val("rst_revive", slot_revive_o, 0);
        check_val("rst_alive", alive_mask_o, 0);
        check_val("rst_left", enemy_left_o, 0);
        check_val("rst_cleared", all_cleared_o, 0);
        check_val("rst_x", spawn_x_o, 32);
        reset_ni = 1'b1;
        cycles(1);

        // First spawn latency, then the delayed second spawn.
        base = rev_cnt;
        pulse_start();
        cycles(2);
        check_val("t1_no_early_revive", slot_revive_o, 0);
        cycles(1);
        check_val("t1_revive_slot0", slot_revive_o, 1);
        check_val("t1_x", spawn_x_o, 32);
        check_val("t1_left", enemy_left_o, 20);
        cycles(1);
        check_val("t1_pulse_width", slot_revive_o, 0);
        check_val("t1_alive", alive_mask_o, 1);
        pulse_tick(); pulse_tick();
        cycles(4);
        check_val("t1_two_ticks_no_spawn", rev_cnt - base, 1);
        pulse_tick();
        cycles(2);
        check_val("t1_slot1_not_yet", slot_revive_o, 0);
        cycles(1);
        check_val("t1_revive_slot1", slot_revive_o, 2);
        check_val("t1_x1", spawn_x_o, 224);
        cycles(1);

        // Full pool: ticks alone never spawn; a death frees slot 0.
        base = rev_cnt;
        repeat (10) begin pulse_tick(); cycles(1); end
        check_val("t2_full_no_revive", rev_cnt - base, 0);
        pulse_die(2'b01);
        check_val("t2_alive_after_die", alive_mask_o, 2);
        check_val("t2_left_after_die", enemy_left_o, 19);
        cycles(2);
        check_val("t2_not_yet", slot_revive_o, 0);
        cycles(1);
        check_val("t2_revive_slot0", slot_revive_o, 1);
        check_val("t2_x2", spawn_x_o, 416);
        cycles(1);
        check_val("t2_alive_full", alive_mask_o, 3);

        // Point 0 blocked: one extra CHECK cycle, spawn at point 1.
        block_mask = 3'b001;
        repeat (3) pulse_tick();
        pulse_die(2'b10);
        cycles(3);
        check_val("t3_one_cycle_late", slot_revive_o, 0);
        cycles(1);
        check_val("t3_revive_slot1", slot_revive_o, 2);
        check_val("t3_x_skip", spawn_x_o, 224);
        cycles(1);

        // All points blocked: back to WAIT with a one-second reload.
        block_mask = 3'b111;
        repeat (3) pulse_tick();
        base = rev_cnt;
        pulse_die(2'b01);
        check_val("t3_left", enemy_left_o, 17);
        cycles(10);
        check_val("t3_all_blocked", rev_cnt - base, 0);
        block_mask = 3'b000;
        cycles(5);
        check_val("t3_reload_delay1", rev_cnt - base, 0);
        pulse_tick();
        cycles(2);
        check_val("t3_after_tick_not_yet", slot_revive_o, 0);
        cycles(1);
        check_val("t3_revive_after_retry", slot_revive_o, 1);
        check_val("t3_x_retry", spawn_x_o, 416);
        cycles(1);

        // Restart mid-round.
        pulse_start();
        check_val("t5_restart_alive", alive_mask_o, 0);
        check_val("t5_restart_left", enemy_left_o, 20);
        cycles(3);
        check_val("t5_restart_revive", int'(slot_revive_o != 2'b00), 1);
        cycles(1);
        check_val("t5_restart_left2", enemy_left_o, 20);

        // Asynchronous reset while in CHECK.
        repeat (3) pulse_tick();
        cycles(2);
        base = rev_cnt;
        reset_ni = 1'b0;
        #1;
        check_val("t5_rst_revive", slot_revive_o, 0);
        check_val("t5_rst_alive", alive_mask_o, 0);
        check_val("t5_rst_left", enemy_left_o, 0);
        check_val("t5_rst_x", spawn_x_o, 32);
        cycles(3);
        reset_ni = 1'b1;
        cycles(10);
        check_val("t5_no_revive_after_rst", rev_cnt - base, 0);

        // Short round on the TOTAL_ENEMIES=3 instance.
        start3 = 1'b1; cycles(1); start3 = 1'b0;
        check_val("t4_left_start", left3, 3);
        for (int i = 0; i < 3; i++) begin
            got = 2'b00;
            for (int k = 0; k < 20 && got == 2'b00; k++) begin
                cycles(1);
                got = rev3;
            end
            check_val("t4_revive_slot", got, (i % 2 == 0) ? 1 : 2);
            cycles(1);
            check_val("t4_left_before_kill", left3, 3 - i);
            die3 = got; cycles(1); die3 = 2'b00;
            check_val("t4_left_after_kill", left3, 2 - i);
            repeat (3) begin tick3 = 1'b1; cycles(1); tick3 = 1'b0; end
        end
        check_val("t4_cleared", cleared3, 1);
        cycles(5);
        check_val("t4_cleared_held", cleared3, 1);
        check_val("t4_left_zero", left3, 0);
        start3 = 1'b1; cycles(1); start3 = 1'b0;
        check_val("t4_cleared_drop", cleared3, 0);
        check_val("t4_left_restart", left3, 3);

`ifdef SPAWN_FREEZE_EN
        // Freeze holds the remaining delay.
        pulse_start();
        cycles(3);
        check_val("t6_first_revive", slot_revive_o, 1);
        cycles(1);
        pulse_tick();
        base = rev_cnt;
        freeze_i = 1'b1;
        repeat (5) begin pulse_tick(); cycles(1); end
        cycles(5);
        check_val("t6_frozen", rev_cnt - base, 0);
        freeze_i = 1'b0;
        pulse_tick();
        cycles(5);
        check_val("t6_delay_resumed", rev_cnt - base, 0);
        pulse_tick();
        cycles(2);
        cycles(1);
        check_val("t6_revive_after_release", slot_revive_o, 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
